// File: rtl/fft_ldr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_ldr_pkg
// Purpose  : Shared types, default parameters and helpers for the FFT bus
//            loader (state encoding, frame geometry, index bit reversal).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fft_ldr_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int          N_WORDS_DEF   = 32;
    localparam int          CALC_WAIT_DEF = 2;
    localparam logic [13:0] BASE_ADDR_DEF = 14'h0088;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_ldr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_ldr_addr_gen
// Purpose  : Maps the 5-bit word index of the write phase to the word offset
//            inside the FFT register window. With FFT_LDR_BITREV_EN defined,
//            the complex point number (index[4:1]) is bit-reversed while the
//            re/im selector (index[0]) is kept; otherwise the mapping is
//            identity.
// Ports    : index  in  5  word index within the frame
//            waddr  out 5  word offset relative to the base address
// Revision : 1.0 - initial release
// ============================================================================
module fft_ldr_addr_gen
    import fft_ldr_pkg::*;
(
    input  logic [4:0] index,
    output logic [4:0] waddr
);

`ifdef FFT_LDR_BITREV_EN
    assign waddr = {bitrev4(index[4:1]), index[0]};
`else
    assign waddr = index;
`endif

endmodule
`default_nettype wire

// File: rtl/fft_bus_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_bus_loader
// Purpose  : Peripheral-bus initiator for the 16-point FFT peripheral.
//            Streams N_WORDS samples into the register window, waits
//            CALC_WAIT cycles, then reads N_WORDS results back one at a time
//            onto a valid/ready result stream.
//            Write address order is natural, or point-bit-reversed when the
//            FFT_LDR_BITREV_EN macro is defined. Reads are always natural.
// Ports    : mclk, puc_rst            clock, async active-high reset
//            start / busy / done      frame control and status
//            s_valid/s_ready/s_data   sample input stream (16 bit)
//            r_valid/r_ready/r_data   result output stream (16 bit)
//            per_addr/per_din/per_en/per_we/per_dout  peripheral bus
// Revision : 1.0 - initial release
// ============================================================================
module fft_bus_loader
    import fft_ldr_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          N_WORDS   = N_WORDS_DEF,
    parameter int          CALC_WAIT = CALC_WAIT_DEF
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);

    state_t     state;
    logic [4:0] index;
    logic [7:0] wait_cnt;
    logic [4:0] waddr;

    fft_ldr_addr_gen u_addr_gen (
        .index (index),
        .waddr (waddr)
    );

    // All outputs are registered; a bus cycle is set up in the cycle before
    // it appears, so the bus defaults to idle every cycle unless a branch
    // below schedules a transfer.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state    <= S_IDLE;
            index    <= 5'd0;
            wait_cnt <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 16'h0000;
            per_addr <= 14'h0000;
            per_din  <= 16'h0000;
            per_en   <= 1'b0;
            per_we   <= 2'b00;
        end else begin
            per_addr <= 14'h0000;
            per_din  <= 16'h0000;
            per_en   <= 1'b0;
            per_we   <= 2'b00;
            done     <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_WRITE;
                        index   <= 5'd0;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (s_valid && s_ready) begin
                        per_en   <= 1'b1;
                        per_we   <= 2'b11;
                        per_din  <= s_data;
                        per_addr <= BASE_ADDR + {9'd0, waddr};
                        if (index == LAST_IDX) begin
                            // Stop before the index wraps; the read phase
                            // restarts it from zero anyway.
                            state    <= S_WAIT;
                            s_ready  <= 1'b0;
                            index    <= 5'd0;
                            wait_cnt <= 8'(CALC_WAIT);
                        end else begin
                            index <= index + 5'd1;
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state    <= S_READ;
                        index    <= 5'd0;
                        per_en   <= 1'b1;
                        per_addr <= BASE_ADDR;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end

                S_READ: begin
                    // Responder drives per_dout combinationally this cycle.
                    r_data  <= per_dout;
                    r_valid <= 1'b1;
                    state   <= S_HOLD;
                end

                S_HOLD: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        if (index == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            index    <= index + 5'd1;
                            state    <= S_READ;
                            per_en   <= 1'b1;
                            per_addr <= BASE_ADDR + {9'd0, index + 5'd1};
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bus_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bus_loader
// Purpose  : Directed self-checking bench for fft_bus_loader: reset values,
//            abort by reset mid-write, full frames with natural or
//            bit-reversed write addressing (FFT_LDR_BITREV_EN), result
//            ordering and rate, back-pressure stall and ignored start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bus_loader;

    logic        mclk;
    logic        puc_rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] r_data;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    fft_bus_loader dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Responder: read data is the address XOR 0x5A5A.
    assign per_dout = per_en ? ({2'b00, per_addr} ^ 16'h5A5A) : 16'h0000;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Bus / stream log filled by the monitor.
    logic [13:0] wr_addr [0:255];
    logic [15:0] wr_data [0:255];
    int          wr_cyc  [0:255];
    logic [13:0] rd_addr [0:255];
    logic [15:0] rd_din  [0:255];
    int          rd_cyc  [0:255];
    logic [15:0] res_data[0:255];
    int          res_cyc [0:255];
    int wr_n = 0, rd_n = 0, res_n = 0, done_n = 0, odd_we_n = 0;

    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) begin
        if (per_en && per_we == 2'b11) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] <= per_addr;
                wr_data[wr_n] <= per_din;
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end else if (per_en && per_we == 2'b00) begin
            if (rd_n < 256) begin
                rd_addr[rd_n] <= per_addr;
                rd_din[rd_n]  <= per_din;
                rd_cyc[rd_n]  <= cyc;
            end
            rd_n <= rd_n + 1;
        end else if (per_en) begin
            odd_we_n <= odd_we_n + 1;
        end
        if (r_valid && r_ready) begin
            if (res_n < 256) begin
                res_data[res_n] <= r_data;
                res_cyc[res_n]  <= cyc;
            end
            res_n <= res_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] exp_waddr(input int k);
        logic [4:0] kk;
        kk = 5'(k);
`ifdef FFT_LDR_BITREV_EN
        return 14'h0088 + {9'd0, kk[1], kk[2], kk[3], kk[4], kk[0]};
`else
        return 14'h0088 + {9'd0, kk};
`endif
    endfunction

    function automatic logic [15:0] exp_rd(input int k);
        logic [13:0] a;
        a = 14'h0088 + 14'(k);
        return {2'b00, a} ^ 16'h5A5A;
    endfunction

    task automatic pulse_start();
        @(negedge mclk);
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1'b1);
    endtask

    task automatic send_words(input int n, input int gap, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge mclk);
            end
            s_valid = 1'b1;
            s_data  = base + 16'(k);
            begin
                int g;
                g = 0;
                while (!s_ready && g < 200) begin
                    @(negedge mclk);
                    g++;
                end
                if (g >= 200) check_val("s_ready_timeout", s_ready, 1'b1);
            end
            @(negedge mclk);
        end
        s_valid = 1'b0;
        s_data  = 16'h0000;
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_n < target && g < 2000) begin
            @(negedge mclk);
            g++;
        end
        check_val("done_count", done_n, target);
        repeat (3) @(negedge mclk);
    endtask

    task automatic check_frame(input int wb, input int rb, input int qb, input logic [15:0] dbase);
        check_val("wr_count", wr_n - wb, 32);
        check_val("rd_count", rd_n - rb, 32);
        check_val("res_count", res_n - qb, 32);
        for (int k = 0; k < 32; k++) begin
            check_val($sformatf("wr_addr[%0d]", k), wr_addr[wb + k], exp_waddr(k));
            check_val($sformatf("wr_data[%0d]", k), wr_data[wb + k], dbase + 16'(k));
            check_val($sformatf("rd_addr[%0d]", k), rd_addr[rb + k], 14'h0088 + 14'(k));
            check_val($sformatf("rd_din[%0d]", k), rd_din[rb + k], 16'h0000);
            check_val($sformatf("res[%0d]", k), res_data[qb + k], exp_rd(k));
        end
        check_val("first_read_gap", rd_cyc[rb] - wr_cyc[wb + 31], 3);
        check_val("res0_value", res_data[qb], 16'h5AD2);
        check_val("end_busy", busy, 1'b0);
        check_val("end_done", done, 1'b0);
        check_val("odd_we", odd_we_n, 0);
    endtask

    initial begin
        int wb, rb, qb, g, stall_bus, stall_bad;
        logic found;
        logic [15:0] hold;

        puc_rst = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        r_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge mclk);
        check_val("rst_ctl", {busy, done, s_ready, r_valid, per_en, per_we}, 0);
        check_val("rst_addr", per_addr, 14'h0000);
        check_val("rst_din", per_din, 16'h0000);
        check_val("rst_rdata", r_data, 16'h0000);
        @(negedge mclk);
        puc_rst = 1'b0;

        // Abort by reset after 10 handshakes.
        pulse_start();
        send_words(10, 0, 16'h0300);
        check_val("pre_abort_wr", per_en, 1'b1);
        #2 puc_rst = 1'b1;
        #1;
        check_val("abort_bus", {per_en, per_we}, 0);
        check_val("abort_addr", per_addr, 14'h0000);
        check_val("abort_din", per_din, 16'h0000);
        check_val("abort_ctl", {busy, s_ready, r_valid, done}, 0);
        @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);

        // Frame 1: back-to-back samples, no back-pressure.
        wb = wr_n; rb = rd_n; qb = res_n;
        r_ready = 1'b1;
        pulse_start();
        send_words(32, 0, 16'h0000);
        wait_done(1);
        check_frame(wb, rb, qb, 16'h0000);
        check_val("post_rst_first_addr", wr_addr[wb], 14'h0088);
        check_val("wr_back_to_back", wr_cyc[wb + 31] - wr_cyc[wb], 31);
        check_val("res_rate", res_cyc[qb + 31] - res_cyc[qb], 62);
`ifdef FFT_LDR_BITREV_EN
        check_val("bitrev_w2", wr_addr[wb + 2], 14'h0098);
        check_val("bitrev_w3", wr_addr[wb + 3], 14'h0099);
        check_val("bitrev_w30", wr_addr[wb + 30], 14'h00A6);
`else
        check_val("nat_w31", wr_addr[wb + 31], 14'h00A7);
`endif

        // Frame 2: gapped samples, stall on word 5, start pulsed in READ.
        wb = wr_n; rb = rd_n; qb = res_n;
        pulse_start();
        send_words(32, 1, 16'hA000);
        found = 1'b0;
        g = 0;
        while (!found && g < 500) begin
            @(negedge mclk);
            g++;
            if (per_en && per_we == 2'b00 && per_addr == 14'h008D) found = 1'b1;
        end
        check_val("stall_found", found, 1'b1);
        r_ready = 1'b0;
        start   = 1'b1;
        @(negedge mclk);
        start   = 1'b0;
        hold = r_data;
        check_val("stall_hold_data", hold, 16'h5AD7);
        stall_bus = 0;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (per_en) stall_bus++;
            if (!r_valid || r_data !== hold) stall_bad++;
            @(negedge mclk);
        end
        check_val("stall_no_bus", stall_bus, 0);
        check_val("stall_hold", stall_bad, 0);
        r_ready = 1'b1;
        wait_done(2);
        check_frame(wb, rb, qb, 16'hA000);
        check_val("gap_writes", wr_cyc[wb + 31] - wr_cyc[wb], 62);

        // The start pulse seen during READ must not have launched a frame.
        repeat (10) @(negedge mclk);
        check_val("ignored_start_frames", done_n, 2);
        check_val("ignored_start_idle", {busy, s_ready, per_en}, 0);
        check_val("ignored_start_wr", wr_n - wb, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
